// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: skid-buffer states and the
// bit positions of the {N,Z,C} flags inside a 3-bit flag vector.
package alu_result_stage_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fifo_state_e;

   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;
   localparam int FLAG_W = 3;

endpackage

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational N/Z/C flag generator; also instantiated by the writeback stage.
module flag_gen
   import alu_result_stage_pkg::*;
#(
   parameter int width = 8
) (
   input  logic [width-1:0]  res,
   input  logic              co,
   output logic [FLAG_W-1:0] flags
);

   always_comb begin
      flags         = '0;
      flags[FLAG_N] = res[width-1];
      flags[FLAG_Z] = (res == '0);
      flags[FLAG_C] = co;
   end

endmodule

// File: rtl/alu_result_stage.sv
// Result stage after the shifter: computes flags at capture and holds up to
// two results in a skid buffer so in_ready never depends on out_ready.
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] in_res,
   input  logic             in_co,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] out_res,
   output logic [2:0]       out_flags,
   output logic [2:0]       status,
   output logic [7:0]       commit_cnt
);

   fifo_state_e        state_q, state_d;
   logic [width-1:0]   head_res_q, head_res_d;
   logic [2:0]         head_flags_q, head_flags_d;
   logic [width-1:0]   tail_res_q, tail_res_d;
   logic [2:0]         tail_flags_q, tail_flags_d;
   logic               in_ready_q, in_ready_d;
   logic [2:0]         status_q, status_d;
   logic [7:0]         commit_cnt_q, commit_cnt_d;

   logic [2:0]         in_flags;
   logic               in_xfer;
   logic               out_xfer;

   flag_gen #(.width(width)) u_flag_gen (
      .res   (in_res),
      .co    (in_co),
      .flags (in_flags)
   );

   assign out_valid = (state_q != EMPTY);
   assign in_xfer   = in_valid && in_ready_q;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      state_d      = state_q;
      head_res_d   = head_res_q;
      head_flags_d = head_flags_q;
      tail_res_d   = tail_res_q;
      tail_flags_d = tail_flags_q;
      status_d     = status_q;
      commit_cnt_d = commit_cnt_q;

      unique case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d      = ONE;
               head_res_d   = in_res;
               head_flags_d = in_flags;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               head_res_d   = in_res;
               head_flags_d = in_flags;
            end else if (in_xfer) begin
               state_d      = FULL;
               tail_res_d   = in_res;
               tail_flags_d = in_flags;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so the second entry simply moves up
            if (out_xfer) begin
               state_d      = ONE;
               head_res_d   = tail_res_q;
               head_flags_d = tail_flags_q;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (out_xfer) begin
         status_d     = head_flags_q;
         commit_cnt_d = commit_cnt_q + 8'd1;
      end

      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         head_res_q   <= '0;
         head_flags_q <= '0;
         tail_res_q   <= '0;
         tail_flags_q <= '0;
         in_ready_q   <= 1'b0;
         status_q     <= '0;
         commit_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         head_res_q   <= head_res_d;
         head_flags_q <= head_flags_d;
         tail_res_q   <= tail_res_d;
         tail_flags_q <= tail_flags_d;
         in_ready_q   <= in_ready_d;
         status_q     <= status_d;
         commit_cnt_q <= commit_cnt_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_res    = head_res_q;
   assign out_flags  = head_flags_q;
   assign status     = status_q;
   assign commit_cnt = commit_cnt_q;

endmodule
